// File: rtl/sfr_pkg.sv
// Shared definitions for the serial frame receiver: FSM encodings and line idle level.
package sfr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } sfr_state_t;

    // Serial line level between frames; a start bit is the opposite level.
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sfr_shift_core.sv
// Serial shift-in register with shift enable and synchronous clear.
module sfr_shift_core #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // LSB-first frames enter at the MSB and move right; MSB-first frames enter at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST != 0) q <= {q[WIDTH-2:0], din};
            else                q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Completed words are held on Q with a valid/rd handshake; a frame that completes
// while an unread word is held is dropped and flagged as overrun.
module serial_frame_receiver
    import sfr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial_in,
    input  logic             rd,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sfr_state_t        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              pe, pe_nxt;
    logic              shift_en, shift_clr, complete;
    logic [WIDTH-1:0]  shreg;

    sfr_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (shift_clr),
        .shift_en (shift_en),
        .din      (serial_in),
        .q        (shreg)
    );

    // Frame FSM state, bit counter and pending parity result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pe    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pe    <= pe_nxt;
        end
    end

    // Next-state and datapath controls; nothing advances on edges without en.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pe_nxt    = pe;
        shift_en  = 1'b0;
        shift_clr = 1'b0;
        complete  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (serial_in != IDLE_LEVEL) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        pe_nxt    = 1'b0;
                        shift_clr = 1'b1;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt == LAST) begin
                        // Counter parks at the last index rather than wrapping.
                        if (PARITY_EN != 0) state_nxt = PAR;
                        else                state_nxt = STOP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                PAR: begin
                    // Even parity: a 1 here means the ones count including parity is odd.
                    pe_nxt    = (^shreg) ^ serial_in;
                    state_nxt = STOP;
                end
                STOP: begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output hold register and rd handshake; a same-edge rd frees the slot for a new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q          <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete && (!valid || rd)) begin
            Q          <= shreg;
            valid      <= 1'b1;
            parity_err <= pe;
            frame_err  <= ~serial_in;
            if (valid) overrun <= 1'b0;
        end else if (complete) begin
            overrun <= 1'b1;
        end else if (rd && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=4, even parity, LSB first).
module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       serial_in;
    logic       rd;
    logic [3:0] Q;
    logic       valid, parity_err, frame_err, overrun;

    int errors = 0;
    int checks = 0;

    serial_frame_receiver #(
        .WIDTH     (4),
        .PARITY_EN (1),
        .MSB_FIRST (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .serial_in  (serial_in),
        .rd         (rd),
        .Q          (Q),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit per en edge; slow mode inserts an en=0 edge before each sampled edge.
    task automatic send_bit(input logic b, input logic slow);
        serial_in = b;
        if (slow) begin
            en = 1'b0;
            @(posedge clk); #1;
            en = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // start, d0..d3 (LSB first), parity, stop; rd_stop drives rd on the stop-sample edge.
    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                              input logic rd_stop, input logic slow);
        send_bit(1'b0, slow);
        for (int i = 0; i < 4; i++) send_bit(d[i], slow);
        send_bit(par, slow);
        rd = rd_stop;
        send_bit(stop, slow);
        rd = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic pop();
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] q, input logic v,
                           input logic pe, input logic fe, input logic ov);
        chk({tag, ".Q"}, 32'(Q), 32'(q));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(pe));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; serial_in = 1'b1; rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk_out("idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean frame 0xD (d=1,0,1,1; par=1)
        send_frame(4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("frame_d", 4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();
        chk_out("pop_d", 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        chk_out("rd_no_valid", 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);

        // Parity error
        send_frame(4'hD, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("par_err", 4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
        pop();
        chk_out("par_err_pop", 4'hD, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stop bit error, then a clean frame 0x5 (parity 0)
        send_frame(4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("stop_err", 4'hD, 1'b1, 1'b0, 1'b1, 1'b0);
        pop();
        send_bit(1'b1, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("after_ferr", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();

        // Overrun: second frame 0x3 (parity 0) dropped
        send_frame(4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("overrun", 4'hD, 1'b1, 1'b0, 1'b0, 1'b1);
        pop();
        chk_out("overrun_pop", 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);

        // rd on the stop edge frees the slot for 0x3; frames back to back
        send_frame(4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("rd_on_stop", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();

        // Reset mid-frame after d1, then frame 0x6 (parity 0)
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b1;
        @(posedge clk); #1;
        chk_out("mid_reset_hold", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("after_reset", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();

        // en toggled: frame 0xA (parity 0)
        send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_out("en_toggle", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();
        chk_out("en_toggle_pop", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
